// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the pong match logic.
//   FIELD_MAX : largest legal coordinate on the 64x64 playfield
//   coord_t   : 6-bit unsigned playfield coordinate
//   score_t   : 4-bit unsigned player score
//   state_t   : match state machine encoding (idle/serve/play/point/over)
// -----------------------------------------------------------------------------
package pong_pkg;

  localparam int FIELD_MAX = 63;

  typedef logic [5:0] coord_t;
  typedef logic [3:0] score_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

endpackage

// File: rtl/paddle_hit_check.sv
// -----------------------------------------------------------------------------
// paddle_hit_check
// Combinational test of whether the ball sits on the face column of one
// paddle and within the rows that paddle covers.
//   Parameters:
//     PADDLE_H   : paddle height in rows (covers top .. top+PADDLE_H-1)
//     RIGHT_SIDE : 0 = paddle faces right (face is col+1),
//                  1 = paddle faces left  (face is col-1)
//   Ports:
//     bx, by : ball position
//     col    : column the paddle occupies
//     top    : top row of the paddle
//     hit    : ball is touching the paddle face
// -----------------------------------------------------------------------------
module paddle_hit_check #(
  parameter int PADDLE_H   = 8,
  parameter bit RIGHT_SIDE = 1'b0
) (
  input  logic [5:0] bx,
  input  logic [5:0] by,
  input  logic [5:0] col,
  input  logic [5:0] top,
  output logic       hit
);

  logic [6:0] face_x;
  logic [6:0] ball_x;
  logic [6:0] ball_y;
  logic [6:0] row_lo;
  logic [6:0] row_hi;

  // All compares are done one bit wider than a coordinate so a paddle whose
  // span runs past row 63 simply extends off the field instead of wrapping
  // back around to row 0.
  assign ball_x = {1'b0, bx};
  assign ball_y = {1'b0, by};
  assign row_lo = {1'b0, top};
  assign row_hi = row_lo + 7'(PADDLE_H - 1);
  assign face_x = RIGHT_SIDE ? ({1'b0, col} - 7'd1) : ({1'b0, col} + 7'd1);

  assign hit = (ball_x == face_x) && (ball_y >= row_lo) && (ball_y <= row_hi);

endmodule

// File: rtl/collision_score_unit.sv
// -----------------------------------------------------------------------------
// collision_score_unit
// Upstream stage of the ball mover. On every game tick it samples the ball
// and paddle positions, raises one-cycle collision / score strobes, and runs
// the match state machine with both score counters and the win decision.
//
// Build option:
//   PONG_DEUCE_EN - when defined a win needs score >= WIN_SCORE and a lead of
//                   at least two; a 14-14 tie is folded back to 13-13 so the
//                   4-bit counters never overflow. When undefined the first
//                   player to reach WIN_SCORE wins.
//
// Ports:
//   clk              : system clock, rising edge
//   reset            : asynchronous active-low reset
//   start            : level, begins a match from IDLE or OVER
//   tick             : one-cycle game-step enable
//   bx, by           : ball position
//   p1y, p2y         : top rows of the left / right paddles
//   paddle_collision : pulse, ball touched a paddle
//   wall_collision   : pulse, ball touched the top or bottom wall
//   sc1, sc2         : pulse, player 1 / player 2 scored
//   serve            : level, high while serving
//   score1, score2   : player scores
//   game_over        : level, high once the match is decided
//   winner           : 0 = player 1, 1 = player 2 (valid with game_over)
// -----------------------------------------------------------------------------
module collision_score_unit
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_TICKS = 32,
  parameter int PADDLE_H    = 8,
  parameter int PADDLE_L_X  = 2,
  parameter int PADDLE_R_X  = 61,
  parameter int HOLDOFF     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic [5:0] bx,
  input  logic [5:0] by,
  input  logic [5:0] p1y,
  input  logic [5:0] p2y,
  output logic       paddle_collision,
  output logic       wall_collision,
  output logic       sc1,
  output logic       sc2,
  output logic       serve,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic       winner
);

  localparam score_t     WIN_S      = score_t'(WIN_SCORE);
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_TICKS);
  localparam logic [2:0] HOLD_LOAD  = 3'(HOLDOFF);
  localparam coord_t     COL_L      = coord_t'(PADDLE_L_X);
  localparam coord_t     COL_R      = coord_t'(PADDLE_R_X);
  localparam coord_t     EDGE_MAX   = coord_t'(FIELD_MAX);

  state_t     state;
  logic [7:0] serve_cnt;
  logic [2:0] hold_cnt;
  logic       point_p2;

  logic       hit_l;
  logic       hit_r;
  logic       goal_right;
  logic       goal_left;
  logic       wall_hit;
  logic       paddle_ok;

  score_t     scorer_old;
  score_t     scorer_new;
  logic       win;
`ifdef PONG_DEUCE_EN
  score_t     other_score;
  logic       tie14;
`endif

  paddle_hit_check #(
    .PADDLE_H  (PADDLE_H),
    .RIGHT_SIDE(1'b0)
  ) u_left (
    .bx (bx),
    .by (by),
    .col(COL_L),
    .top(p1y),
    .hit(hit_l)
  );

  paddle_hit_check #(
    .PADDLE_H  (PADDLE_H),
    .RIGHT_SIDE(1'b1)
  ) u_right (
    .bx (bx),
    .by (by),
    .col(COL_R),
    .top(p2y),
    .hit(hit_r)
  );

  // Field events for the current sample; only acted on in PLAY with tick.
  // A paddle touch only counts once the holdoff window has expired, which
  // stops a ball lingering on the face from re-triggering the bounce.
  assign goal_right = (bx == EDGE_MAX);
  assign goal_left  = (bx == 6'd0);
  assign wall_hit   = (by == 6'd0) || (by == EDGE_MAX);
  assign paddle_ok  = (hit_l || hit_r) && (hold_cnt == 3'd0);

  // Score that the POINT cycle will write for whoever scored, and whether
  // that point ends the match.
  always_comb begin
    scorer_old = point_p2 ? score2 : score1;
    scorer_new = scorer_old + 4'd1;
`ifdef PONG_DEUCE_EN
    other_score = point_p2 ? score1 : score2;
    tie14       = (scorer_new == 4'd14) && (other_score == 4'd14);
    win         = (scorer_new >= WIN_S) &&
                  ({1'b0, scorer_new} >= ({1'b0, other_score} + 5'd2));
`else
    win         = (scorer_new == WIN_S);
`endif
  end

  // Match state machine, counters and all registered outputs. Pulses are
  // cleared every cycle and only raised for the single cycle after the tick
  // that qualified them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      serve_cnt        <= 8'd0;
      hold_cnt         <= 3'd0;
      point_p2         <= 1'b0;
      paddle_collision <= 1'b0;
      wall_collision   <= 1'b0;
      sc1              <= 1'b0;
      sc2              <= 1'b0;
      serve            <= 1'b0;
      score1           <= 4'd0;
      score2           <= 4'd0;
      game_over        <= 1'b0;
      winner           <= 1'b0;
    end else begin
      paddle_collision <= 1'b0;
      wall_collision   <= 1'b0;
      sc1              <= 1'b0;
      sc2              <= 1'b0;

      // Holdoff drains on every tick; a fresh paddle hit below overrides it.
      if (tick && (hold_cnt != 3'd0)) begin
        hold_cnt <= hold_cnt - 3'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            score1    <= 4'd0;
            score2    <= 4'd0;
            serve_cnt <= SERVE_LOAD;
            serve     <= 1'b1;
            state     <= SERVE;
          end
        end

        SERVE: begin
          if (tick) begin
            serve_cnt <= serve_cnt - 8'd1;
            if (serve_cnt <= 8'd1) begin
              serve <= 1'b0;
              state <= PLAY;
            end
          end
        end

        PLAY: begin
          if (tick) begin
            // A goal outranks anything else seen on the same tick.
            if (goal_right) begin
              sc1      <= 1'b1;
              point_p2 <= 1'b0;
              state    <= POINT;
            end else if (goal_left) begin
              sc2      <= 1'b1;
              point_p2 <= 1'b1;
              state    <= POINT;
            end else begin
              if (paddle_ok) begin
                paddle_collision <= 1'b1;
                hold_cnt         <= HOLD_LOAD;
              end
              wall_collision <= wall_hit;
            end
          end
        end

        POINT: begin
          if (point_p2) begin
            score2 <= scorer_new;
          end else begin
            score1 <= scorer_new;
          end
`ifdef PONG_DEUCE_EN
          if (tie14) begin
            score1 <= 4'd13;
            score2 <= 4'd13;
          end
`endif
          if (win) begin
            game_over <= 1'b1;
            winner    <= point_p2;
            state     <= OVER;
          end else begin
            serve_cnt <= SERVE_LOAD;
            serve     <= 1'b1;
            state     <= SERVE;
          end
        end

        OVER: begin
          if (start) begin
            score1    <= 4'd0;
            score2    <= 4'd0;
            game_over <= 1'b0;
            serve_cnt <= SERVE_LOAD;
            serve     <= 1'b1;
            state     <= SERVE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
